mul_serial_acc: RTL and testbench

Sequencer/accumulator on the controlling end of the bit-serial partial-product interface of the 8-bit binary-serial multiplier. Accepts a start request, walks the multiplier-bit index 0..WIDTH-1 into the partial-product stage (drives its `en`, `clr` and `idx` inputs), and receives one partial product per bit. It shift-accumulates the partial products into a signed two's-complement product. It then presents the product under a valid/ready handshake. It sits between the PE's operand-staging logic and the PE's output register.

---
 rtl/mul_serial_pkg.sv | 20 ++
 rtl/mul_serial_cnt.sv | 29 ++
 rtl/mul_serial_acc.sv | 119 +++++++++++
 tb/tb_mul_serial_acc.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul_serial_pkg.sv
// rtl/mul_serial_pkg.sv - shared types and constants for the serial multiplier sequencer
package mul_serial_pkg;

  localparam int WIDTH_DEF = 8;

  // Index width for a given operand width (at least one bit)
  function automatic int depth_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int DEPTH_DEF = depth_of(WIDTH_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul_serial_cnt.sv
// rtl/mul_serial_cnt.sv - multiplier-bit index counter with clear, enable and terminal count
module mul_serial_cnt
  import mul_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = depth_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [DEPTH-1:0] cnt,
  output logic             tc
);

  // Clear wins over enable so a restart or abort always begins at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == DEPTH'(WIDTH - 1));

endmodule

// File: rtl/mul_serial_acc.sv
// rtl/mul_serial_acc.sv - bit-serial multiply sequencer and signed shift-accumulator
module mul_serial_acc
  import mul_serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = depth_of(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  output logic                      o_ready,
  input  logic                      i_flush,
  output logic                      o_en,
  output logic                      o_clr,
  output logic [DEPTH-1:0]          o_idx,
  input  logic signed [2*WIDTH-1:0] i_pp,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [2*WIDTH-1:0] o_result
);

  localparam int PW = 2 * WIDTH;
  localparam logic [DEPTH-1:0] IDX_MSB = DEPTH'(WIDTH - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [DEPTH-1:0]       cnt;
  logic                   cnt_tc;
  logic                   accept;
  logic [DEPTH-1:0]       shamt;
  logic signed [PW-1:0]   pp_shift;
  logic signed [PW-1:0]   acc;

  assign accept = (state == IDLE) && i_start && !i_flush;

  mul_serial_cnt #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (i_flush || accept),
    .en    (state == RUN),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  // i_pp belongs to the index issued one cycle earlier, hence cnt-1 in RUN
  always_comb begin
    shamt    = (state == DRAIN) ? IDX_MSB : (cnt - 1'b1);
    pp_shift = i_pp <<< shamt;
  end

  // Accumulate positive-weight bits in RUN, subtract the sign bit in DRAIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (i_flush || accept) begin
      acc <= '0;
    end else begin
      case (state)
        RUN:     if (cnt != '0) acc <= acc + pp_shift;
        DRAIN:   acc <= acc - pp_shift;
        DONE:    if (i_ready) acc <= '0;
        default: ;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides start and handshake
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (cnt_tc) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) state_nxt = IDLE;
  end

  // Output decode from state; clr also pulses on acceptance and abort
  always_comb begin
    o_ready = 1'b0;
    o_en    = 1'b0;
    o_clr   = i_flush;
    o_idx   = '0;
    o_valid = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_start) o_clr = 1'b1;
      end
      RUN: begin
        o_en  = 1'b1;
        o_idx = cnt;
      end
      DRAIN: o_idx = IDX_MSB;
      DONE: begin
        o_idx   = IDX_MSB;
        o_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_result = acc;

endmodule

// File: tb/tb_mul_serial_acc.sv
// tb/tb_mul_serial_acc.sv - directed scoreboard bench for mul_serial_acc with a partial-product stage model
module tb_mul_serial_acc;

  localparam int W = 8;
  localparam int D = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    i_start;
  logic                    o_ready;
  logic                    i_flush;
  logic                    o_en;
  logic                    o_clr;
  logic [D-1:0]            o_idx;
  logic signed [2*W-1:0]   i_pp;
  logic                    o_valid;
  logic                    i_ready;
  logic signed [2*W-1:0]   o_result;

  logic signed [W-1:0]     mcand;
  logic signed [W-1:0]     mplier;
  logic [D-1:0]            idx_q;

  logic signed [2*W-1:0]   sb_q[$];
  int                      n_cmp = 0;
  int                      n_err = 0;

  always #5 clk = ~clk;

  mul_serial_acc #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .o_ready  (o_ready),
    .i_flush  (i_flush),
    .o_en     (o_en),
    .o_clr    (o_clr),
    .o_idx    (o_idx),
    .i_pp     (i_pp),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
  );

  // Partial-product stage: registered index, combinational select of the multiplicand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     idx_q <= '0;
    else if (o_clr) idx_q <= '0;
    else if (o_en)  idx_q <= o_idx;
  end
  assign i_pp = mplier[idx_q] ? {{W{mcand[W-1]}}, mcand} : '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic run_mul(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input int hold);
    logic signed [2*W-1:0] expv;
    int cyc;
    mcand   = a;
    mplier  = b;
    i_ready = (hold == 0);
    i_start = 1'b1;
    expv    = a * b;
    sb_q.push_back(expv);
    #1;
    chk("ready_at_start", o_ready, 1);
    chk("clr_on_start", o_clr, 1);
    step();
    i_start = 1'b0;
    cyc = 1;
    for (int k = 0; k < W; k++) begin
      chk("idx_seq", o_idx, k);
      chk("en_run", o_en, 1);
      step();
      cyc++;
    end
    while (!o_valid && cyc < 40) begin
      step();
      cyc++;
    end
    chk("latency", cyc, 10);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      expv = sb_q.pop_front();
      chk("result", o_result, expv);
      for (int h = 0; h < hold; h++) begin
        step();
        chk("hold_valid", o_valid, 1);
        chk("hold_result", o_result, expv);
      end
    end
    i_ready = 1'b1;
    step();
    chk("idle_ready", o_ready, 1);
    chk("idle_valid", o_valid, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    mcand   = '0;
    mplier  = '0;
    step();
    step();
    chk("rst_ready", o_ready, 1);
    chk("rst_en", o_en, 0);
    chk("rst_clr", o_clr, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_result", o_result, 0);
    rst_n = 1'b1;
    step();

    run_mul(8'sd5, 8'sd3, 0);
    run_mul(8'sd5, -8'sd3, 0);
    run_mul(-8'sd3, 8'sd5, 0);
    run_mul(-8'sd128, -8'sd128, 0);
    run_mul(-8'sd128, 8'sd127, 0);
    run_mul(8'sd7, -8'sd9, 3);
    run_mul(8'sd5, 8'sd3, 0);

    // Abort in RUN at cnt=4
    mcand = 8'sd9; mplier = 8'sd11;
    i_start = 1'b1;
    sb_q.push_back(16'sd99);
    step();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("flush_idx", o_idx, 4);
    i_flush = 1'b1;
    #1;
    chk("flush_clr", o_clr, 1);
    step();
    i_flush = 1'b0;
    void'(sb_q.pop_back());
    chk("flush_idle", o_ready, 1);
    for (int k = 0; k < 12; k++) begin
      chk("flush_no_valid", o_valid, 0);
      step();
    end
    run_mul(8'sd5, 8'sd3, 0);

    // Asynchronous reset mid-RUN
    mcand = 8'sd13; mplier = -8'sd7;
    i_start = 1'b1;
    sb_q.push_back(-16'sd91);
    step();
    i_start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    chk("arst_ready", o_ready, 1);
    chk("arst_en", o_en, 0);
    chk("arst_clr", o_clr, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_idx", o_idx, 0);
    chk("arst_result", o_result, 0);
    step();
    rst_n = 1'b1;
    step();
    run_mul(-8'sd77, 8'sd101, 0);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
